// File: rtl/clkdiv_pkg.sv
// Shared constants and types for the multi-channel clock divider.
package clkdiv_pkg;

  localparam int CLKDIV_WIDTH = 28;
  localparam int MAX_CHANNELS = 8;

  typedef logic [CLKDIV_WIDTH-1:0] div_t;

  // 32 Hz from a 100 MHz oscillator
  localparam div_t CLKDIV_DEFAULT_DIV = 28'd3125000;

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: counter, shadow/active divisor pair, square wave and tick.
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int               WIDTH       = CLKDIV_WIDTH,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = CLKDIV_DEFAULT_DIV
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic             sync_in,
  input  logic [WIDTH-1:0] divisor_in,
  output logic             clock_out,
  output logic             tick,
  output logic             busy
);

  logic [WIDTH-1:0] counter;
  logic [WIDTH-1:0] active_div;
  logic [WIDTH-1:0] pending_div;
  logic             pending;
  logic             period_end;

  assign period_end = (counter >= active_div - WIDTH'(1));
  assign busy       = pending;

  always_ff @(posedge clock_in) begin
    if (reset) begin
      counter     <= '0;
      active_div  <= DEFAULT_DIV;
      pending_div <= DEFAULT_DIV;
      pending     <= 1'b0;
      clock_out   <= 1'b0;
      tick        <= 1'b0;
    end else begin
      if (load) pending_div <= divisor_in;

      if (sync_in) begin
        // Phase alignment: restart the period with the newest divisor
        counter <= '0;
        tick    <= 1'b0;
        if (pending) begin
          active_div <= pending_div;
          clock_out  <= (pending_div >= WIDTH'(2));
        end else begin
          clock_out  <= (active_div >= WIDTH'(2));
        end
        pending <= load;
      end else if (active_div == '0) begin
        // Stopped channel: a pending divisor takes over without waiting for a boundary
        counter   <= '0;
        clock_out <= 1'b0;
        tick      <= 1'b0;
        if (pending) active_div <= pending_div;
        pending <= load;
      end else if (enable) begin
        clock_out <= (counter < (active_div >> 1));
        if (period_end) begin
          counter <= '0;
          tick    <= 1'b1;
          if (pending) active_div <= pending_div;
          pending <= load;
        end else begin
          counter <= counter + WIDTH'(1);
          tick    <= 1'b0;
          if (load) pending <= 1'b1;
        end
      end else begin
        tick <= 1'b0;
        if (load) pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/multi_clock_divider.sv
// Multi-channel programmable clock divider; CLKDIV_SYNC_EN adds a sync_in phase-align input.
module multi_clock_divider
  import clkdiv_pkg::*;
#(
  parameter int               CHANNELS    = 4,
  parameter int               WIDTH       = CLKDIV_WIDTH,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = CLKDIV_DEFAULT_DIV
) (
  input  logic                clock_in,
  input  logic                reset,
`ifdef CLKDIV_SYNC_EN
  input  logic                sync_in,
`endif
  input  logic [CHANNELS-1:0] enable,
  input  logic [CHANNELS-1:0] load,
  input  logic [WIDTH-1:0]    divisor_in,
  output logic [CHANNELS-1:0] clock_out,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] busy
);

  logic sync_int;

`ifdef CLKDIV_SYNC_EN
  assign sync_int = sync_in;
`else
  assign sync_int = 1'b0;
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    clkdiv_channel #(
      .WIDTH      (WIDTH),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_ch (
      .clock_in  (clock_in),
      .reset     (reset),
      .enable    (enable[i]),
      .load      (load[i]),
      .sync_in   (sync_int),
      .divisor_in(divisor_in),
      .clock_out (clock_out[i]),
      .tick      (tick[i]),
      .busy      (busy[i])
    );
  end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Directed bench for multi_clock_divider (2 channels, default divisor scaled to 10).
module tb_multi_clock_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  enable;
  logic [1:0]  load;
  logic [27:0] divisor_in;
  logic [1:0]  clock_out;
  logic [1:0]  tick;
  logic [1:0]  busy;
`ifdef CLKDIV_SYNC_EN
  logic        sync_in = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multi_clock_divider #(
    .CHANNELS   (2),
    .WIDTH      (28),
    .DEFAULT_DIV(28'd10)
  ) dut (
    .clock_in  (clk),
    .reset     (reset),
`ifdef CLKDIV_SYNC_EN
    .sync_in   (sync_in),
`endif
    .enable    (enable),
    .load      (load),
    .divisor_in(divisor_in),
    .clock_out (clock_out),
    .tick      (tick),
    .busy      (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Step until channel ch ticks or the limit expires; n is the step count.
  task automatic wait_tick(input int ch, input int limit, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!tick[ch] && n < limit);
  endtask

  initial begin
    int n, first, hi0, hi1, tk0, tk1;
    logic [7:0] seq0, seq1;

    reset = 1'b1; enable = 2'b00; load = 2'b00; divisor_in = '0;
    step(); step();
    chk("reset_clock_out", clock_out, 2'b00);
    chk("reset_tick", tick, 2'b00);
    chk("reset_busy", busy, 2'b00);

    // Default divisor 10: 5 high, 5 low, tick every 10 cycles
    reset = 1'b0; enable = 2'b11;
    first = 0; hi0 = 0; hi1 = 0; tk0 = 0; tk1 = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      hi0 += int'(clock_out[0]); hi1 += int'(clock_out[1]);
      tk0 += int'(tick[0]);      tk1 += int'(tick[1]);
      if (tick[0] && first == 0) first = i;
    end
    chk("def_first_tick", first, 10);
    chk("def_high0", hi0, 10);
    chk("def_ticks0", tk0, 2);
    chk("def_high1", hi1, 10);
    chk("def_ticks1", tk1, 2);

    // Load 4 on ch0 mid-period; takes effect at the old period end
    step(); step(); step();
    load = 2'b01; divisor_in = 28'd4;
    step();
    load = 2'b00;
    chk("load4_busy0", busy[0], 1'b1);
    chk("load4_busy1", busy[1], 1'b0);
    for (int i = 0; i < 5; i++) step();
    chk("load4_busy_hold", busy[0], 1'b1);
    step();
    chk("load4_busy_drop", busy[0], 1'b0);
    chk("load4_tick0", tick[0], 1'b1);
    chk("load4_tick1", tick[1], 1'b1);
    for (int i = 7; i >= 0; i--) begin
      step();
      seq0[i] = clock_out[0];
      seq1[i] = clock_out[1];
    end
    chk("div4_wave0", seq0, 8'b1100_1100);
    chk("div10_wave1", seq1, 8'b1111_1000);

    // Divisor 3 then 1 on ch1
    load = 2'b10; divisor_in = 28'd3;
    step();
    load = 2'b00;
    step();
    chk("div3_boundary_tick", tick[1], 1'b1);
    chk("div3_busy", busy[1], 1'b0);
    tk1 = 0;
    for (int i = 5; i >= 0; i--) begin
      step();
      seq1[i] = clock_out[1];
      tk1 += int'(tick[1]);
    end
    chk("div3_wave1", seq1[5:0], 6'b100100);
    chk("div3_ticks1", tk1, 2);
    load = 2'b10; divisor_in = 28'd1;
    step();
    load = 2'b00;
    step(); step();
    chk("div1_boundary_tick", tick[1], 1'b1);
    chk("div1_busy", busy[1], 1'b0);
    hi1 = 0; tk1 = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      hi1 += int'(clock_out[1]); tk1 += int'(tick[1]);
    end
    chk("div1_high", hi1, 0);
    chk("div1_ticks", tk1, 5);

    // Freeze ch0 mid-period for 10 cycles
    wait_tick(0, 20, n);
    chk("align_tick0", tick[0], 1'b1);
    step(); step();
    enable = 2'b10;
    hi0 = 0; tk0 = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      hi0 += int'(clock_out[0]); tk0 += int'(tick[0]);
    end
    chk("freeze_high", hi0, 10);
    chk("freeze_ticks", tk0, 0);
    enable = 2'b11;
    step();
    chk("resume_clk", clock_out[0], 1'b0);
    chk("resume_no_tick", tick[0], 1'b0);
    step();
    chk("resume_tick", tick[0], 1'b1);

    // Load 5 then 7: last write wins
    load = 2'b01; divisor_in = 28'd5;
    step();
    divisor_in = 28'd7;
    step();
    load = 2'b00;
    chk("lww_busy", busy[0], 1'b1);
    step(); step();
    chk("lww_tick", tick[0], 1'b1);
    chk("lww_busy_drop", busy[0], 1'b0);
    hi0 = 0; tk0 = 0;
    for (int i = 0; i < 7; i++) begin
      step();
      hi0 += int'(clock_out[0]); tk0 += int'(tick[0]);
    end
    chk("div7_high", hi0, 3);
    chk("div7_ticks", tk0, 1);
    chk("div7_end_tick", tick[0], 1'b1);

    // Reset mid-period, with a load in the same cycle
    step(); step();
    reset = 1'b1; load = 2'b11; divisor_in = 28'd4;
    step();
    chk("rst_mid_clock_out", clock_out, 2'b00);
    chk("rst_mid_tick", tick, 2'b00);
    chk("rst_mid_busy", busy, 2'b00);
    reset = 1'b0; load = 2'b00;
    wait_tick(0, 30, n);
    chk("rst_default_period", n, 10);
    chk("rst_default_tick1", tick[1], 1'b1);

    // Divisor 0 stops the channel; a new divisor applies immediately
    load = 2'b01; divisor_in = 28'd0;
    step();
    load = 2'b00;
    wait_tick(0, 20, n);
    chk("div0_boundary", n, 9);
    hi0 = 0; tk0 = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      hi0 += int'(clock_out[0]); tk0 += int'(tick[0]);
    end
    chk("div0_high", hi0, 0);
    chk("div0_ticks", tk0, 0);
    load = 2'b01; divisor_in = 28'd4;
    step();
    load = 2'b00;
    chk("div0_load_busy", busy[0], 1'b1);
    step();
    chk("div0_busy_drop", busy[0], 1'b0);
    wait_tick(0, 20, n);
    chk("div0_restart_period", n, 4);

`ifdef CLKDIV_SYNC_EN
    load = 2'b10; divisor_in = 28'd8;
    step();
    load = 2'b00;
    sync_in = 1'b1;
    step();
    sync_in = 1'b0;
    chk("sync_clock_out", clock_out, 2'b11);
    chk("sync_tick", tick, 2'b00);
    chk("sync_busy", busy, 2'b00);
    tk0 = 0; tk1 = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      tk0 += int'(tick[0]); tk1 += int'(tick[1]);
    end
    chk("sync_ticks0", tk0, 4);
    chk("sync_ticks1", tk1, 2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
